shift_req_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8-bit left/right rotate stage (`Shift_left_or_right_stage`). It accepts rotate requests over valid/ready handshakes and grants one requester at a time. It drives the shared stage from registered operands and returns a registered result tagged with the requester ID. It sits between client logic (e.g. display/LED pattern engines) and the single shifter instance, so the combinational datapath is never driven by two clients at once.

---
 rtl/shift_req_arbiter_pkg.sv | 22 ++
 rtl/Shift_left_or_right_stage.sv | 24 ++
 rtl/shift_req_arbiter.sv | 124 ++++++++++++
 tb/tb_shift_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_req_arbiter_pkg.sv
// Shared types and constants for the rotate-stage arbiter.
// State encodings, direction codes and a bit-reverse helper.
package shift_req_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = v[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/Shift_left_or_right_stage.sv
// Combinational 8-bit rotate stage, left or right by 0-7.
// Right rotate reuses the left rotator on the bit-reversed operand.
module Shift_left_or_right_stage
   import shift_req_arbiter_pkg::*;
(
   input  logic [7:0] a,
   input  logic [2:0] amt,
   input  logic       choice,
   output logic [7:0] y
);

   logic [7:0]  src;
   logic [15:0] dbl;
   logic [7:0]  rot;

   // select operand orientation, rotate left, restore orientation
   always_comb begin
      src = (choice == DIR_RIGHT) ? rev8(a) : a;
      dbl = {src, src} << amt;
      rot = dbl[15:8];
      y   = (choice == DIR_RIGHT) ? rev8(rot) : rot;
   end

endmodule

// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter and sequencer for one shared rotate stage.
// IDLE grants, EXEC computes from latched operands, RESP holds the result.
module shift_req_arbiter
   import shift_req_arbiter_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int RESET_PRIO = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [3*N_REQ-1:0]   req_amt,
   input  logic [N_REQ-1:0]     req_dir,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_data,
   output logic                 rsp_id,
   output logic                 busy
);

   localparam logic RST_LAST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

   state_e     state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] op_data_q, op_data_d;
   logic [2:0] op_amt_q, op_amt_d;
   logic       op_dir_q, op_dir_d;
   logic       op_id_q, op_id_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_id_q, rsp_id_d;

   logic       any_req;
   logic       win;
   logic [7:0] stage_y;

   Shift_left_or_right_stage u_stage (
      .a      (op_data_q),
      .amt    (op_amt_q),
      .choice (op_dir_q),
      .y      (stage_y)
   );

   // pick a winner; on contention the requester not served last goes
   always_comb begin
      any_req = |req_valid;
      win     = 1'b0;
      unique case (1'b1)
         (req_valid[0] && req_valid[1]): win = ~last_grant_q;
         (req_valid[1] && !req_valid[0]): win = 1'b1;
         default: win = 1'b0;
      endcase
   end

   // next-state, operand capture and result capture
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_data_d    = op_data_q;
      op_amt_d     = op_amt_q;
      op_dir_d     = op_dir_q;
      op_id_d      = op_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      req_ready    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               req_ready[win] = 1'b1;
               op_data_d      = win ? req_data[15:8] : req_data[7:0];
               op_amt_d       = win ? req_amt[5:3] : req_amt[2:0];
               op_dir_d       = req_dir[win];
               op_id_d        = win;
               last_grant_d   = win;
               state_d        = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d = stage_y;
            rsp_id_d   = op_id_q;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= RST_LAST;
         op_data_q    <= '0;
         op_amt_q     <= '0;
         op_dir_q     <= 1'b0;
         op_id_q      <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_data_q    <= op_data_d;
         op_amt_q     <= op_amt_d;
         op_dir_q     <= op_dir_d;
         op_id_q      <= op_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   // registered outputs and status
   always_comb begin
      rsp_valid = (state_q == ST_RESP);
      rsp_data  = rsp_data_q;
      rsp_id    = rsp_id_q;
      busy      = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed bench for shift_req_arbiter with a response scoreboard.
// Expected results are queued on accept and compared on rsp_valid.
module tb_shift_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_data;
   logic [5:0]  req_amt;
   logic [1:0]  req_dir;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_id;
   logic        busy;

   typedef struct {
      logic       id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   shift_req_arbiter #(.N_REQ(2), .RESET_PRIO(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_dir   (req_dir),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
      logic [15:0] t;
      t = {8'h00, a} << k;
      return t[7:0] | t[15:8];
   endfunction

   function automatic logic [7:0] rotr(input logic [7:0] a, input int k);
      logic [15:0] t;
      t = {a, 8'h00} >> k;
      return t[15:8] | t[7:0];
   endfunction

   function automatic logic [7:0] model(input logic [7:0] a, input int k,
                                        input logic d);
      return d ? rotr(a, k) : rotl(a, k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int id, input logic [7:0] d,
                       input logic [2:0] a, input logic dr);
      req_data[8*id +: 8] = d;
      req_amt[3*id +: 3]  = a;
      req_dir[id]         = dr;
   endtask

   // drive one request, wait for its ready, queue the expected result
   task automatic send(input int id, input logic [7:0] d,
                       input logic [2:0] a, input logic dr);
      bit   ok;
      exp_t e;
      load(id, d, a, dr);
      req_valid[id] = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            ok = 1;
            break;
         end
      end
      check("accept", 32'(ok), 32'd1);
      check("ready_onehot", 32'(req_ready), 32'(2'b01 << id));
      e.id   = id[0];
      e.data = model(d, int'(a), dr);
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   // wait for a response, check latency, compare against scoreboard
   task automatic recv(input int exp_lat);
      int   n;
      bit   ok;
      exp_t e;
      ok = 0;
      n  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1;
            n  = i;
            break;
         end
      end
      check("rsp_arrive", 32'(ok), 32'd1);
      if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("rsp_data", 32'(rsp_data), 32'(e.data));
         check("rsp_id", 32'(rsp_id), 32'(e.id));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         grants;
      int         rsps;
      int         last_g;
      bit         ok;
      logic [7:0] hold_d;
      logic       hold_id;
      exp_t       e;

      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_amt   = '0;
      req_dir   = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'h00);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;

      // single left and right operations
      send(0, 8'h81, 3'd1, 1'b0);
      check("exec_ready_low", 32'(req_ready), 32'd0);
      recv(2);
      send(1, 8'h81, 3'd1, 1'b1);
      recv(2);
      send(1, 8'hA5, 3'd0, 1'b1);
      recv(2);

      // reset while holding a response aborts it
      rsp_ready = 1'b0;
      send(0, 8'h3C, 3'd2, 1'b0);
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1;
            break;
         end
      end
      check("pre_rst_valid", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rsp_data", 32'(rsp_data), 32'h00);
      sb.delete();
      @(posedge clk);
      #1;

      // contention: both requesters continuously valid
      load(0, 8'hF0, 3'd4, 1'b0);
      load(1, 8'h0F, 3'd2, 1'b1);
      req_valid = 2'b11;
      grants = 0;
      rsps   = 0;
      last_g = -1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            check("cont_grant", 32'(req_ready), 32'(2'b01 << (grants % 2)));
            if (last_g >= 0) check("cont_spacing", 32'(cyc - last_g), 32'd3);
            last_g = cyc;
            e.id   = req_ready[1];
            e.data = req_ready[1] ? model(8'h0F, 2, 1'b1)
                                  : model(8'hF0, 4, 1'b0);
            sb.push_back(e);
            grants++;
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("cont_sb", 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               check("cont_data", 32'(rsp_data), 32'(e.data));
               check("cont_id", 32'(rsp_id), 32'(e.id));
            end
            rsps++;
         end
         @(posedge clk);
         #1;
         if (grants >= 4) req_valid = 2'b00;
         if (grants >= 4 && rsps >= 4) break;
      end
      check("cont_grants", 32'(grants), 32'd4);
      check("cont_rsps", 32'(rsps), 32'd4);

      // backpressure: hold response, pending request must wait
      rsp_ready = 1'b0;
      send(0, 8'h96, 3'd3, 1'b1);
      load(1, 8'h5A, 3'd5, 1'b0);
      req_valid[1] = 1'b1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1;
            break;
         end
      end
      check("bp_arrive", 32'(ok), 32'd1);
      hold_d  = rsp_data;
      hold_id = rsp_id;
      if (sb.size() == 0) begin
         check("bp_sb", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("bp_data", 32'(rsp_data), 32'(e.data));
         check("bp_id", 32'(rsp_id), 32'(e.id));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_stable_d", 32'(rsp_data), 32'(hold_d));
         check("bp_stable_id", 32'(rsp_id), 32'(hold_id));
         check("bp_ready_low", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      check("bp_idle_valid", 32'(rsp_valid), 32'd0);
      check("bp_next_grant", 32'(req_ready), 32'(2'b10));
      e.id   = 1'b1;
      e.data = model(8'h5A, 5, 1'b0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      recv(2);

      // sweep all amounts both directions on 0x01
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) begin
            send(d, 8'h01, 3'(k), d[0]);
            recv(2);
         end
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
